// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PID codes, packet classes, tx FSM states,
// the CRC5 seed and the latched request struct.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_PING  = 4'b0100;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;

  localparam logic [4:0] CRC5_SEED = 5'h1f;

  typedef enum logic [1:0] {
    PKT_TOKEN,
    PKT_HS,
    PKT_ILLEGAL
  } pkt_class_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PID,
    TX_ADDR,
    TX_CRC,
    TX_GAP
  } tx_state_e;

  typedef struct packed {
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       inj;
  } tx_req_t;

  function automatic pkt_class_e pid_class(input logic [3:0] pid);
    if (pid[1:0] == 2'b01 || pid == PID_PING) return PKT_TOKEN;
    if (pid[1:0] == 2'b10)                    return PKT_HS;
    return PKT_ILLEGAL;
  endfunction

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

endpackage

// File: rtl/crc5_t_if.sv
// Request and phy byte-stream bundle of the short-packet transmitter.
// slave = transmitter side, master = link control / phy side.
interface crc5_t_if;
  logic       tx_req_valid;
  logic       tx_req_ready;
  logic [3:0] tx_pid;
  logic [6:0] tx_addr;
  logic [3:0] tx_endp;
  logic       tx_done;
  logic       tx_pid_err;
  logic       tx_lp_sop;
  logic       tx_lp_eop;
  logic       tx_lp_valid;
  logic       tx_lp_ready;
  logic [7:0] tx_lp_data;

  modport slave (
    input  tx_req_valid, tx_pid, tx_addr, tx_endp, tx_lp_ready,
    output tx_req_ready, tx_done, tx_pid_err,
    output tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data
  );

  modport master (
    output tx_req_valid, tx_pid, tx_addr, tx_endp, tx_lp_ready,
    input  tx_req_ready, tx_done, tx_pid_err,
    input  tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_data
  );
endinterface

// File: rtl/crc5.sv
// Combinational USB CRC5 (x^5+x^2+1) over 11 bits, d[0] first on the wire.
// c_out is the complemented register; the wire field is its bit reversal.
module crc5 (
  input  logic [4:0]  c,
  input  logic [10:0] d,
  output logic [4:0]  c_out
);
  logic [4:0] r;
  logic       fb;

  always_comb begin
    r  = c;
    fb = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ d[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    c_out = ~r;
  end
endmodule

// File: rtl/crc5_t.sv
// USB TOKEN/HANDSHAKE transmitter: latches one request and streams PID, ADDR,
// CRC bytes to the phy. Optional CRC5_TX_ERR_INJ_EN adds crc_inject.
module crc5_t
  import usb_pkg::*;
#(
  parameter int IPG_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
`ifdef CRC5_TX_ERR_INJ_EN
  input  logic      crc_inject,
`endif
  crc5_t_if.slave   bus
);
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  tx_state_e     state_q, state_d;
  tx_req_t       req_q, req_d, req_in;
  logic [GW-1:0] gap_q, gap_d;

  logic       ready_q, done_q, err_q, sop_q, eop_q, valid_q;
  logic [7:0] data_q;
  logic       done_d, err_d, sop_d, eop_d, valid_d;
  logic [7:0] data_d;

  logic       accept, beat;
  logic [4:0] crc_out, crc_field;

  assign accept = bus.tx_req_valid & ready_q;
  assign beat   = valid_q & bus.tx_lp_ready;

  always_comb begin
    req_in.pid  = bus.tx_pid;
    req_in.addr = bus.tx_addr;
    req_in.endp = bus.tx_endp;
`ifdef CRC5_TX_ERR_INJ_EN
    req_in.inj  = crc_inject;
`else
    req_in.inj  = 1'b0;
`endif
  end

  // CRC only feeds the CRC byte, which is loaded while req_q is already stable.
  crc5 u_crc5 (
    .c     (CRC5_SEED),
    .d     ({req_q.endp, req_q.addr}),
    .c_out (crc_out)
  );
  assign crc_field = bitrev5(crc_out) ^ {4'b0000, req_q.inj};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      TX_IDLE: if (accept) begin
        req_d = req_in;
        if (pid_class(req_in.pid) == PKT_ILLEGAL) err_d   = 1'b1;
        else                                      state_d = TX_PID;
      end
      TX_PID: if (beat) begin
        if (pid_class(req_q.pid) == PKT_HS) begin
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = (IPG_CYCLES > 0) ? TX_GAP : TX_IDLE;
        end else begin
          state_d = TX_ADDR;
        end
      end
      TX_ADDR: if (beat) state_d = TX_CRC;
      TX_CRC: if (beat) begin
        done_d  = 1'b1;
        gap_d   = '0;
        state_d = (IPG_CYCLES > 0) ? TX_GAP : TX_IDLE;
      end
      TX_GAP: begin
        if (gap_q == GAP_LAST) state_d = TX_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it;
  // a stalled beat leaves state/req untouched, which keeps the byte stable.
  always_comb begin
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    data_d  = 8'h00;
    unique case (state_d)
      TX_PID: begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        eop_d   = (pid_class(req_d.pid) == PKT_HS);
        data_d  = {~req_d.pid, req_d.pid};
      end
      TX_ADDR: begin
        valid_d = 1'b1;
        data_d  = {req_d.endp[0], req_d.addr};
      end
      TX_CRC: begin
        valid_d = 1'b1;
        eop_d   = 1'b1;
        data_d  = {crc_field, req_d.endp[3:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      req_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gap_q   <= gap_d;
      ready_q <= (state_d == TX_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.tx_req_ready = ready_q;
  assign bus.tx_done      = done_q;
  assign bus.tx_pid_err   = err_q;
  assign bus.tx_lp_sop    = sop_q;
  assign bus.tx_lp_eop    = eop_q;
  assign bus.tx_lp_valid  = valid_q;
  assign bus.tx_lp_data   = data_q;

endmodule
